// File: rtl/note_pkg.sv
// ----------------------------------------------------------------------------
// note_pkg
// Shared types and default constants for the note voice tracker.
//   note_t        : note code {pitch, octave} at the default note width
//   release_evt_t : one release record {note, final duration, slot} at the
//                   default widths
//   *_DEF         : default parameter values used by note_voice_tracker and
//                   release_arbiter
// ----------------------------------------------------------------------------
package note_pkg;

    localparam int          NOTE_W_DEF  = 8;
    localparam int          DUR_W_DEF   = 32;
    localparam int          VOICES_DEF  = 5;
    localparam int unsigned DUR_MAX_DEF = 159_999_999;
    localparam int          SLOT_W_DEF  = $clog2(VOICES_DEF);

    typedef logic [NOTE_W_DEF-1:0] note_t;

    typedef struct packed {
        note_t                 note;
        logic [DUR_W_DEF-1:0]  dur;
        logic [SLOT_W_DEF-1:0] slot;
    } release_evt_t;

endpackage

// File: rtl/note_voice_tracker_release_arbiter.sv
// ----------------------------------------------------------------------------
// release_arbiter
// Presents the lowest-index pending release record on the event port and
// returns a one-hot pop for the slot whose event completes its handshake.
// Purely combinational; the pending records live in the parent.
// Ports:
//   pend_in       : per-slot pending flags
//   note_in       : per-slot pending notes, slot s at [s*NOTE_W +: NOTE_W]
//   dur_in        : per-slot pending durations, slot s at [s*DUR_W +: DUR_W]
//   evt_ready_in  : consumer accepts the presented event
//   evt_*_out     : presented event (valid, note, duration, slot)
//   pop_out       : one-hot, slot whose event is accepted this cycle
// ----------------------------------------------------------------------------
module release_arbiter
    import note_pkg::*;
#(
    parameter int  VOICES = VOICES_DEF,
    parameter int  NOTE_W = NOTE_W_DEF,
    parameter int  DUR_W  = DUR_W_DEF,
    localparam int SLOT_W = $clog2(VOICES)
) (
    input  logic [VOICES-1:0]        pend_in,
    input  logic [VOICES*NOTE_W-1:0] note_in,
    input  logic [VOICES*DUR_W-1:0]  dur_in,
    input  logic                     evt_ready_in,
    output logic                     evt_valid_out,
    output logic [NOTE_W-1:0]        evt_note_out,
    output logic [DUR_W-1:0]         evt_dur_out,
    output logic [SLOT_W-1:0]        evt_slot_out,
    output logic [VOICES-1:0]        pop_out
);

    logic [VOICES-1:0] sel;

    // Scanning downwards lets the lowest pending slot overwrite any higher one.
    always_comb begin
        sel           = '0;
        evt_valid_out = 1'b0;
        evt_note_out  = '0;
        evt_dur_out   = '0;
        evt_slot_out  = '0;
        for (int s = VOICES - 1; s >= 0; s--) begin
            if (pend_in[s]) begin
                sel           = '0;
                sel[s]        = 1'b1;
                evt_valid_out = 1'b1;
                evt_note_out  = note_in[s*NOTE_W +: NOTE_W];
                evt_dur_out   = dur_in[s*DUR_W +: DUR_W];
                evt_slot_out  = SLOT_W'(s);
            end
        end
    end

    assign pop_out = sel & {VOICES{evt_ready_in}};

endmodule

// File: rtl/note_voice_tracker.sv
// ----------------------------------------------------------------------------
// note_voice_tracker
// Binds each held MIDI note from the per-cycle lane snapshot to a stable voice
// slot, counts how long each slot has been held, and reports every released
// note as (note, final duration, slot) on a valid/ready event port.
// Ports:
//   clk_in, rst_in         : clock, synchronous active-high reset
//   valid_note_in          : snapshot strobe
//   note_on_in, note_in    : per-lane held flag and note code
//   notes_out              : note bound to each slot (0 when free)
//   durations_out          : cycles held per slot (0 when free)
//   active_out             : slot occupied
//   alloc_overflow_out     : one-cycle pulse, a new note found no free slot
//   evt_valid/ready/note/dur/slot : release event handshake
//   evt_drop_out           : one-cycle pulse, an unsent event was overwritten
// Configuration macro:
//   DURATION_SATURATE_EN   : defined -> counters hold at DUR_MAX;
//                            undefined -> counters wrap DUR_MAX -> 0.
// ----------------------------------------------------------------------------
module note_voice_tracker
    import note_pkg::*;
#(
    parameter int          VOICES  = VOICES_DEF,
    parameter int          NOTE_W  = NOTE_W_DEF,
    parameter int          DUR_W   = DUR_W_DEF,
    parameter int unsigned DUR_MAX = DUR_MAX_DEF,
    localparam int         SLOT_W  = $clog2(VOICES)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     valid_note_in,
    input  logic [VOICES-1:0]        note_on_in,
    input  logic [VOICES*NOTE_W-1:0] note_in,
    output logic [VOICES*NOTE_W-1:0] notes_out,
    output logic [VOICES*DUR_W-1:0]  durations_out,
    output logic [VOICES-1:0]        active_out,
    output logic                     alloc_overflow_out,
    output logic                     evt_valid_out,
    input  logic                     evt_ready_in,
    output logic [NOTE_W-1:0]        evt_note_out,
    output logic [DUR_W-1:0]         evt_dur_out,
    output logic [SLOT_W-1:0]        evt_slot_out,
    output logic                     evt_drop_out
);

    logic [NOTE_W-1:0] lane_note [VOICES];
    logic [VOICES-1:0] lane_eff;
    logic [VOICES-1:0] lane_new;
    logic [VOICES-1:0] slot_rel;
    logic [VOICES-1:0] pop;

    logic [VOICES-1:0] active_q, active_d;
    logic [VOICES-1:0] pend_q, pend_d;
    logic [NOTE_W-1:0] note_q  [VOICES];
    logic [NOTE_W-1:0] note_d  [VOICES];
    logic [DUR_W-1:0]  dur_q   [VOICES];
    logic [DUR_W-1:0]  dur_d   [VOICES];
    logic [NOTE_W-1:0] pnote_q [VOICES];
    logic [NOTE_W-1:0] pnote_d [VOICES];
    logic [DUR_W-1:0]  pdur_q  [VOICES];
    logic [DUR_W-1:0]  pdur_d  [VOICES];
    logic              overflow_q, overflow_d;
    logic              drop_q, drop_d;

    logic [VOICES*NOTE_W-1:0] pnote_flat;
    logic [VOICES*DUR_W-1:0]  pdur_flat;

    function automatic logic [DUR_W-1:0] dur_step(input logic [DUR_W-1:0] d);
`ifdef DURATION_SATURATE_EN
        return (d == DUR_W'(DUR_MAX)) ? d : d + DUR_W'(1);
`else
        return (d == DUR_W'(DUR_MAX)) ? '0 : d + DUR_W'(1);
`endif
    endfunction

    // Lane side: a lane counts only if no lower held lane carries the same
    // note; it is new if no active slot already holds that note.
    for (genvar i = 0; i < VOICES; i++) begin : g_lane
        logic dup;
        logic bound;
        assign lane_note[i] = note_in[i*NOTE_W +: NOTE_W];
        always_comb begin
            dup   = 1'b0;
            bound = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (note_on_in[j] && (lane_note[j] == lane_note[i])) dup = 1'b1;
            end
            for (int s = 0; s < VOICES; s++) begin
                if (active_q[s] && (note_q[s] == lane_note[i])) bound = 1'b1;
            end
        end
        assign lane_eff[i] = valid_note_in && note_on_in[i] && !dup;
        assign lane_new[i] = lane_eff[i] && !bound;
    end

    // Slot side: an active slot without a matching counted lane is released.
    for (genvar s = 0; s < VOICES; s++) begin : g_slot
        logic kept;
        always_comb begin
            kept = 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                if (lane_eff[i] && (lane_note[i] == note_q[s])) kept = 1'b1;
            end
        end
        assign slot_rel[s] = valid_note_in && active_q[s] && !kept;

        assign notes_out[s*NOTE_W +: NOTE_W]  = note_q[s];
        assign durations_out[s*DUR_W +: DUR_W] = dur_q[s];
        assign pnote_flat[s*NOTE_W +: NOTE_W] = pnote_q[s];
        assign pdur_flat[s*DUR_W +: DUR_W]    = pdur_q[s];
    end

    always_comb begin
        logic [VOICES-1:0] avail;
        logic              placed;
        placed     = 1'b0;
        active_d   = active_q & ~slot_rel;
        overflow_d = 1'b0;
        // An event popped on this edge is gone, so overwriting it is no drop.
        drop_d     = |(slot_rel & pend_q & ~pop);
        pend_d     = slot_rel | (pend_q & ~pop);
        for (int s = 0; s < VOICES; s++) begin
            note_d[s]  = slot_rel[s] ? '0 : note_q[s];
            dur_d[s]   = (active_q[s] && !slot_rel[s]) ? dur_step(dur_q[s]) : '0;
            pnote_d[s] = slot_rel[s] ? note_q[s] : pnote_q[s];
            pdur_d[s]  = slot_rel[s] ? dur_q[s]  : pdur_q[s];
        end
        // Slots freed by this snapshot are already counted as available.
        avail = ~active_d;
        for (int i = 0; i < VOICES; i++) begin
            if (lane_new[i]) begin
                placed = 1'b0;
                for (int s = 0; s < VOICES; s++) begin
                    if (!placed && avail[s]) begin
                        placed      = 1'b1;
                        avail[s]    = 1'b0;
                        active_d[s] = 1'b1;
                        note_d[s]   = lane_note[i];
                        dur_d[s]    = '0;
                    end
                end
                if (!placed) overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            active_q   <= '0;
            pend_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= 1'b0;
            for (int s = 0; s < VOICES; s++) begin
                note_q[s]  <= '0;
                dur_q[s]   <= '0;
                pnote_q[s] <= '0;
                pdur_q[s]  <= '0;
            end
        end else begin
            active_q   <= active_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
            pnote_q    <= pnote_d;
            pdur_q     <= pdur_d;
        end
    end

    release_arbiter #(
        .VOICES (VOICES),
        .NOTE_W (NOTE_W),
        .DUR_W  (DUR_W)
    ) u_arb (
        .pend_in       (pend_q),
        .note_in       (pnote_flat),
        .dur_in        (pdur_flat),
        .evt_ready_in  (evt_ready_in),
        .evt_valid_out (evt_valid_out),
        .evt_note_out  (evt_note_out),
        .evt_dur_out   (evt_dur_out),
        .evt_slot_out  (evt_slot_out),
        .pop_out       (pop)
    );

    assign active_out         = active_q;
    assign alloc_overflow_out = overflow_q;
    assign evt_drop_out       = drop_q;

endmodule

// File: tb/tb_note_voice_tracker.sv
// ----------------------------------------------------------------------------
// tb_note_voice_tracker
// Two trackers share one stimulus: u_big with the default DUR_MAX and u_sml
// with DUR_MAX=15. A reference model keeps each slot's bound note and age in
// cycles; the reported duration is derived from the age according to the
// counter policy selected by DURATION_SATURATE_EN.
// ----------------------------------------------------------------------------
module tb_note_voice_tracker;

    localparam int V     = 5;
    localparam int NW    = 8;
    localparam int DW    = 32;
    localparam int SW    = 3;
    localparam int BIG   = 159_999_999;
    localparam int SMALL = 15;
`ifdef DURATION_SATURATE_EN
    localparam int SML_AT_100 = 15;
`else
    localparam int SML_AT_100 = 4;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vld = 1'b0;
    logic [V-1:0]  on  = '0;
    logic [V*NW-1:0] nin = '0;
    logic          rdy = 1'b1;

    logic [V*NW-1:0] a_notes, b_notes;
    logic [V*DW-1:0] a_durs, b_durs;
    logic [V-1:0]    a_act, b_act;
    logic            a_ovf, b_ovf, a_ev, b_ev, a_drop, b_drop;
    logic [NW-1:0]   a_en, b_en;
    logic [DW-1:0]   a_ed, b_ed;
    logic [SW-1:0]   a_es, b_es;

    always #5 clk = ~clk;

    note_voice_tracker u_big (
        .clk_in(clk), .rst_in(rst), .valid_note_in(vld), .note_on_in(on), .note_in(nin),
        .notes_out(a_notes), .durations_out(a_durs), .active_out(a_act),
        .alloc_overflow_out(a_ovf), .evt_valid_out(a_ev), .evt_ready_in(rdy),
        .evt_note_out(a_en), .evt_dur_out(a_ed), .evt_slot_out(a_es), .evt_drop_out(a_drop)
    );

    note_voice_tracker #(.DUR_MAX(SMALL)) u_sml (
        .clk_in(clk), .rst_in(rst), .valid_note_in(vld), .note_on_in(on), .note_in(nin),
        .notes_out(b_notes), .durations_out(b_durs), .active_out(b_act),
        .alloc_overflow_out(b_ovf), .evt_valid_out(b_ev), .evt_ready_in(rdy),
        .evt_note_out(b_en), .evt_dur_out(b_ed), .evt_slot_out(b_es), .evt_drop_out(b_drop)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: per slot occupancy, note, age since allocation, and
    // the pending release record (note, age at release).
    bit m_act [V];
    int m_note[V];
    int m_age [V];
    bit m_pend[V];
    int m_pnote[V];
    int m_page[V];
    bit m_ovf;
    bit m_drop;

    function automatic int view(input int age, input int dmax);
`ifdef DURATION_SATURATE_EN
        return (age > dmax) ? dmax : age;
`else
        return age % (dmax + 1);
`endif
    endfunction

    function automatic bit has(input int q[$], input int v);
        foreach (q[k]) if (q[k] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_sel();
        for (int s = 0; s < V; s++) if (m_pend[s]) return s;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit act_n[V]; int note_n[V]; int age_n[V];
        bit pend_n[V]; int pn_n[V]; int pa_n[V];
        int held[$];
        int sel;
        int h;
        bit bound, placed, ovf_n, drop_n;
        sel    = m_sel();
        ovf_n  = 1'b0;
        drop_n = 1'b0;
        for (int s = 0; s < V; s++) begin
            act_n[s]  = m_act[s];
            note_n[s] = m_note[s];
            age_n[s]  = m_act[s] ? m_age[s] + 1 : 0;
            pend_n[s] = m_pend[s] && !((s == sel) && rdy);
            pn_n[s]   = m_pnote[s];
            pa_n[s]   = m_page[s];
        end
        if (rst) begin
            for (int s = 0; s < V; s++) begin
                act_n[s] = 0; note_n[s] = 0; age_n[s] = 0;
                pend_n[s] = 0; pn_n[s] = 0; pa_n[s] = 0;
            end
        end else if (vld) begin
            for (int i = 0; i < V; i++) begin
                if (on[i]) begin
                    h = int'(nin[i*NW +: NW]);
                    if (!has(held, h)) held.push_back(h);
                end
            end
            for (int s = 0; s < V; s++) begin
                if (m_act[s] && !has(held, m_note[s])) begin
                    if (pend_n[s]) drop_n = 1'b1;
                    pend_n[s] = 1'b1;
                    pn_n[s]   = m_note[s];
                    pa_n[s]   = m_age[s];
                    act_n[s]  = 1'b0;
                    note_n[s] = 0;
                    age_n[s]  = 0;
                end
            end
            foreach (held[k]) begin
                bound = 1'b0;
                for (int s = 0; s < V; s++) if (m_act[s] && m_note[s] == held[k]) bound = 1'b1;
                if (!bound) begin
                    placed = 1'b0;
                    for (int s = 0; s < V; s++) begin
                        if (!placed && !act_n[s]) begin
                            placed = 1'b1; act_n[s] = 1'b1; note_n[s] = held[k]; age_n[s] = 0;
                        end
                    end
                    if (!placed) ovf_n = 1'b1;
                end
            end
        end
        for (int s = 0; s < V; s++) begin
            m_act[s] = act_n[s]; m_note[s] = note_n[s]; m_age[s] = age_n[s];
            m_pend[s] = pend_n[s]; m_pnote[s] = pn_n[s]; m_page[s] = pa_n[s];
        end
        m_ovf  = ovf_n;
        m_drop = drop_n;
    endtask

    task automatic check_all();
        int sel;
        logic [V-1:0] exp_act;
        sel = m_sel();
        for (int s = 0; s < V; s++) begin
            exp_act[s] = m_act[s];
            check($sformatf("a_note[%0d]", s), a_notes[s*NW +: NW], m_note[s]);
            check($sformatf("b_note[%0d]", s), b_notes[s*NW +: NW], m_note[s]);
            check($sformatf("a_dur[%0d]", s), a_durs[s*DW +: DW], view(m_age[s], BIG));
            check($sformatf("b_dur[%0d]", s), b_durs[s*DW +: DW], view(m_age[s], SMALL));
        end
        check("a_active", a_act, exp_act);
        check("b_active", b_act, exp_act);
        check("a_overflow", a_ovf, m_ovf);
        check("b_overflow", b_ovf, m_ovf);
        check("a_drop", a_drop, m_drop);
        check("b_drop", b_drop, m_drop);
        check("a_evt_valid", a_ev, sel >= 0);
        check("b_evt_valid", b_ev, sel >= 0);
        if (sel >= 0) begin
            check("a_evt_note", a_en, m_pnote[sel]);
            check("b_evt_note", b_en, m_pnote[sel]);
            check("a_evt_slot", a_es, sel);
            check("b_evt_slot", b_es, sel);
            check("a_evt_dur", a_ed, view(m_page[sel], BIG));
            check("b_evt_dur", b_ed, view(m_page[sel], SMALL));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic snap(input bit v, input logic [V-1:0] o,
                        input int n0, input int n1, input int n2, input int n3, input int n4);
        vld = v;
        on  = o;
        nin = {NW'(n4), NW'(n3), NW'(n2), NW'(n1), NW'(n0)};
    endtask

    initial begin
        snap(0, '0, 0, 0, 0, 0, 0);
        rdy = 1'b1;
        rst = 1'b1;
        cycle();
        cycle();
        check("rst_evt_note", a_en, 0);
        check("rst_evt_dur", a_ed, 0);
        check("rst_evt_slot", a_es, 0);
        rst = 1'b0;

        // Three notes, held for 100 cycles, then 64 released.
        snap(1, 5'b00111, 60, 64, 67, 0, 0);
        cycle();
        check("plan_active", a_act, 5'b00111);
        repeat (60) cycle();
        vld = 1'b0;
        repeat (40) cycle();
        snap(1, 5'b00101, 60, 0, 67, 0, 0);
        cycle();
        check("plan_rel_note", a_en, 64);
        check("plan_rel_slot", a_es, 1);
        check("plan_rel_dur", a_ed, 100);
        check("plan_rel_dur_small", b_ed, SML_AT_100);
        vld = 1'b0;
        cycle();

        // Re-take 64, then swap it for 72 in one snapshot.
        snap(1, 5'b00111, 60, 64, 67, 0, 0);
        repeat (4) cycle();
        snap(1, 5'b00111, 60, 72, 67, 0, 0);
        cycle();
        check("repl_note", a_notes[NW +: NW], 72);
        check("repl_dur", a_durs[DW +: DW], 0);
        check("repl_evt", a_en, 64);

        // Release everything, then duplicate lanes and a full house.
        snap(1, '0, 0, 0, 0, 0, 0);
        repeat (4) cycle();
        snap(1, 5'b11111, 10, 10, 11, 12, 13);
        cycle();
        check("dup_active", a_act, 5'b01111);
        snap(1, 5'b11111, 10, 11, 12, 13, 14);
        cycle();
        check("fill_active", a_act, 5'b11111);
        check("fill_overflow", a_ovf, 0);

        // Back-pressure: two releases queue, slot 1 is overwritten, then drain.
        rdy = 1'b0;
        snap(1, 5'b10101, 10, 0, 12, 0, 14);
        cycle();
        check("hold_slot", a_es, 1);
        check("hold_note", a_en, 11);
        vld = 1'b0;
        cycle();
        check("hold_stable", a_en, 11);
        snap(1, 5'b10111, 10, 20, 12, 0, 14);
        cycle();
        snap(1, 5'b10101, 10, 0, 12, 0, 14);
        cycle();
        check("drop_pulse", a_drop, 1);
        check("drop_note", a_en, 20);
        vld = 1'b0;
        rdy = 1'b1;
        cycle();
        check("drain_slot3", a_es, 3);
        cycle();
        check("drain_empty", a_ev, 0);

        // Reset with events still pending.
        rdy = 1'b0;
        snap(1, 5'b00001, 10, 0, 0, 0, 0);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        vld = 1'b0;
        cycle();
        check("post_rst_valid", a_ev, 0);

        // Randomized snapshots over a narrow note range to force collisions.
        repeat (400) begin
            rst = ($urandom_range(0, 99) == 0);
            vld = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < V; i++) begin
                on[i] = $urandom_range(0, 1);
                nin[i*NW +: NW] = NW'($urandom_range(60, 66));
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
